// File: rtl/team_registry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | team_registry: per-team login registry with find, list and occupancy.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module team_registry #(
  parameter int  ID_W   = 4,
  parameter int  TEAM_W = 1,
  parameter int  DEPTH  = 5,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ID_W-1:0]   userID,
  input  logic [TEAM_W-1:0] team,
  input  logic [1:0]        mode,
  output logic [CNT_W-1:0]  numPly,
  output logic              teamWng,
  output logic              capWng,
  output logic              findRes,
  output logic [ID_W-1:0]   listOut,
  output logic              listValid,
  output logic              listMode
);
  localparam int                NTEAM       = 2 ** TEAM_W;
  localparam int                SLOT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  FULL        = CNT_W'(DEPTH);
  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(DEPTH - 1);
  localparam logic [1:0]        MODE_LOGOUT = 2'b00;
  localparam logic [1:0]        MODE_LOGIN  = 2'b01;
  localparam logic [1:0]        MODE_FIND   = 2'b10;
  localparam logic [1:0]        MODE_LIST   = 2'b11;

  logic [ID_W-1:0]   r_id    [NTEAM][DEPTH];
  logic [DEPTH-1:0]  r_valid [NTEAM];
  logic [CNT_W-1:0]  r_cnt   [NTEAM];
  logic [SLOT_W-1:0] r_ptr;
  logic [TEAM_W-1:0] r_list_team;
  logic              r_list_active;

  logic [TEAM_W-1:0] w_uteam;
  logic              w_mismatch;
  logic              w_hit;
  logic              w_free;
  logic [SLOT_W-1:0] w_hit_idx;
  logic [SLOT_W-1:0] w_free_idx;
  logic [SLOT_W-1:0] w_rd_ptr;
  logic              w_login;
  logic              w_logout;
  logic [CNT_W-1:0]  w_cnt_sel;

  assign w_uteam    = userID[ID_W-1 -: TEAM_W];
  assign w_mismatch = (w_uteam != team);

  // Both searches run in the team owning userID; valid bits alone mark occupancy.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_hit && r_valid[w_uteam][i] && (r_id[w_uteam][i] == userID)) begin
        w_hit     = 1'b1;
        w_hit_idx = SLOT_W'(i);
      end
      if (!w_free && !r_valid[w_uteam][i]) begin
        w_free     = 1'b1;
        w_free_idx = SLOT_W'(i);
      end
    end
  end

  assign w_login  = (mode == MODE_LOGIN) && !w_mismatch && !w_hit && w_free;
  assign w_logout = (mode == MODE_LOGOUT) && w_hit;
  assign w_rd_ptr = (r_list_active && (team == r_list_team)) ? r_ptr : '0;

  // Occupancy of the selected team as it will be after this cycle's operation.
  always_comb begin
    w_cnt_sel = r_cnt[team];
    if (w_login) begin
      w_cnt_sel = r_cnt[team] + 1'b1;
    end else if (w_logout && (w_uteam == team)) begin
      w_cnt_sel = r_cnt[team] - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_login) begin
      r_id[w_uteam][w_free_idx] <= userID;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int t = 0; t < NTEAM; t++) begin
        r_valid[t] <= '0;
        r_cnt[t]   <= '0;
      end
      r_ptr         <= '0;
      r_list_team   <= '0;
      r_list_active <= 1'b0;
      numPly        <= '0;
      capWng        <= 1'b1;
      teamWng       <= 1'b0;
      findRes       <= 1'b0;
      listOut       <= '0;
      listValid     <= 1'b0;
      listMode      <= 1'b0;
    end else begin
      if (w_login) begin
        r_valid[w_uteam][w_free_idx] <= 1'b1;
        r_cnt[w_uteam]               <= r_cnt[w_uteam] + 1'b1;
      end
      if (w_logout) begin
        r_valid[w_uteam][w_hit_idx] <= 1'b0;
        r_cnt[w_uteam]              <= r_cnt[w_uteam] - 1'b1;
      end
      if (mode == MODE_LIST) begin
        r_list_active <= 1'b1;
        r_list_team   <= team;
        r_ptr         <= (w_rd_ptr == LAST_SLOT) ? '0 : w_rd_ptr + 1'b1;
        listValid     <= r_valid[team][w_rd_ptr];
        listOut       <= r_valid[team][w_rd_ptr] ? r_id[team][w_rd_ptr] : '0;
      end else begin
        r_list_active <= 1'b0;
        r_ptr         <= '0;
      end
      numPly   <= w_cnt_sel;
      capWng   <= (w_cnt_sel == '0) || (w_cnt_sel == FULL);
      teamWng  <= (mode == MODE_LOGIN) && w_mismatch;
      findRes  <= (mode == MODE_FIND) && w_hit;
      listMode <= (mode == MODE_LIST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_team_registry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_team_registry: scoreboard bench for team_registry (default params).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_team_registry;
  typedef logic [11:0] obs_t;  // {numPly[2:0], capWng, teamWng, findRes, listOut[3:0], listValid, listMode}

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] userID;
  logic [0:0] team;
  logic [1:0] mode;
  logic [2:0] numPly;
  logic       teamWng, capWng, findRes, listValid, listMode;
  logic [3:0] listOut;

  obs_t exp_q[$];
  obs_t got_q[$];
  int   checks = 0;
  int   errors = 0;

  team_registry #(.ID_W(4), .TEAM_W(1), .DEPTH(5)) dut (
    .CLK(CLK), .RST(RST), .userID(userID), .team(team), .mode(mode),
    .numPly(numPly), .teamWng(teamWng), .capWng(capWng), .findRes(findRes),
    .listOut(listOut), .listValid(listValid), .listMode(listMode)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t mk(input int np, input bit cap, input bit tw, input bit fr,
                              input int lo, input bit lv, input bit lm);
    return {3'(np), cap, tw, fr, 4'(lo), lv, lm};
  endfunction

  function automatic obs_t obs();
    return {numPly, capWng, teamWng, findRes, listOut, listValid, listMode};
  endfunction

  // Called at a negedge (or mid low phase); returns at the following negedge.
  task automatic step(input logic [1:0] m, input logic [3:0] id, input logic t, input obs_t e);
    mode = m; userID = id; team = t;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    got_q.push_back(obs());
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; mode = 2'b10; userID = '0; team = '0;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, g;
    int n = 0;
    RST = 1'b1; #1;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0)); got_q.push_back(obs());
    @(posedge CLK); #1;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0)); got_q.push_back(obs());
    @(negedge CLK); RST = 1'b0;
    step(2'b10, 4'd0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_login_zero();
    obs_t e, g;
    int n = 0;
    do_reset();
    step(2'b01, 4'd0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b10, 4'd0, 1'b0, mk(1, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL login_zero[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_capacity();
    obs_t e, g;
    int n = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) step(2'b01, 4'(i), 1'b0, mk(i, (i == 5), 0, 0, 0, 0, 0));
    step(2'b01, 4'd6, 1'b0, mk(5, 1, 0, 0, 0, 0, 0));
    step(2'b10, 4'd6, 1'b0, mk(5, 1, 0, 0, 0, 0, 0));
    step(2'b10, 4'd3, 1'b0, mk(5, 1, 0, 1, 0, 0, 0));
    step(2'b00, 4'd3, 1'b0, mk(4, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd6, 1'b0, mk(5, 1, 0, 0, 0, 0, 0));
    step(2'b10, 4'd6, 1'b0, mk(5, 1, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL capacity[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_team_mismatch();
    obs_t e, g;
    int n = 0;
    do_reset();
    step(2'b01, 4'd1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd9, 1'b0, mk(1, 0, 1, 0, 0, 0, 0));
    step(2'b10, 4'd1, 1'b0, mk(1, 0, 0, 1, 0, 0, 0));
    step(2'b01, 4'd1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd9, 1'b1, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b10, 4'd9, 1'b0, mk(1, 0, 0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL team_mismatch[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_list();
    obs_t e, g;
    int n = 0;
    int lo[6] = '{1, 7, 3, 0, 0, 1};
    do_reset();
    step(2'b01, 4'd1, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd2, 1'b0, mk(2, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd3, 1'b0, mk(3, 0, 0, 0, 0, 0, 0));
    step(2'b00, 4'd2, 1'b0, mk(2, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd7, 1'b0, mk(3, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) step(2'b11, 4'd0, 1'b0, mk(3, 0, 0, 0, lo[i], (lo[i] != 0), 1));
    step(2'b11, 4'd0, 1'b1, mk(0, 1, 0, 0, 0, 0, 1));
    step(2'b11, 4'd0, 1'b0, mk(3, 0, 0, 0, 1, 1, 1));
    step(2'b10, 4'd7, 1'b0, mk(3, 0, 0, 1, 1, 1, 0));
    step(2'b11, 4'd0, 1'b0, mk(3, 0, 0, 0, 1, 1, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL list[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_logout_absent();
    obs_t e, g;
    int n = 0;
    do_reset();
    step(2'b00, 4'd4, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    step(2'b00, 4'd4, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    step(2'b01, 4'd4, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b00, 4'd4, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    step(2'b01, 4'd12, 1'b1, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b00, 4'd12, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    step(2'b10, 4'd12, 1'b1, mk(0, 1, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL logout_absent[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid_list();
    obs_t e, g;
    int n = 0;
    do_reset();
    step(2'b01, 4'd5, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b01, 4'd6, 1'b0, mk(2, 0, 0, 0, 0, 0, 0));
    step(2'b11, 4'd0, 1'b0, mk(2, 0, 0, 0, 5, 1, 1));
    step(2'b11, 4'd0, 1'b0, mk(2, 0, 0, 0, 6, 1, 1));
    RST = 1'b1; #1;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0)); got_q.push_back(obs());
    RST = 1'b0;
    step(2'b11, 4'd0, 1'b0, mk(0, 1, 0, 0, 0, 0, 1));
    step(2'b01, 4'd5, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    step(2'b11, 4'd0, 1'b0, mk(1, 0, 0, 0, 5, 1, 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_mid_list[%0d] got=%h exp=%h", n, g, e); end
      n++;
    end
  endtask

  initial begin
    mode = 2'b10; userID = '0; team = '0;
    @(negedge CLK);
    test_reset();
    test_login_zero();
    test_capacity();
    test_team_mismatch();
    test_list();
    test_logout_absent();
    test_reset_mid_list();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
